// File: rtl/regfile_wr_arbiter_if.sv
// Writeback arbiter bus: requester handshake, scoreboard issue/hazard ports and
// the registered write port toward the register bank.
interface regfile_wr_arbiter_if #(
   parameter int N_REQ = 3,
   parameter int DW    = 32,
   parameter int AW    = 5
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ*AW-1:0] req_addr;
   logic [N_REQ*DW-1:0] req_data;
   logic [N_REQ-1:0]    req_ready;
   logic                hold;
   logic                issue_valid;
   logic [AW-1:0]       issue_addr;
   logic [AW-1:0]       rd_addr_a;
   logic [AW-1:0]       rd_addr_b;
   logic                rd_hazard;
   logic [AW-1:0]       dir_wra;
   logic [DW-1:0]       di;
   logic                reg_wr;
   logic [31:0]         busy;

   modport master (
      output req_valid, req_addr, req_data, hold, issue_valid, issue_addr,
             rd_addr_a, rd_addr_b,
      input  req_ready, rd_hazard, dir_wra, di, reg_wr, busy
   );

   modport slave (
      input  req_valid, req_addr, req_data, hold, issue_valid, issue_addr,
             rd_addr_a, rd_addr_b,
      output req_ready, rd_hazard, dir_wra, di, reg_wr, busy
   );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin writeback arbiter feeding a register bank, with a pending-write
// scoreboard used for read-after-write hazard detection.
module regfile_wr_arbiter #(
   parameter int N_REQ = 3,
   parameter int DW    = 32,
   parameter int AW    = 5
) (
   input logic                clk,
   input logic                rst,
   regfile_wr_arbiter_if.slave bus
);
   localparam int            PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [PW:0]   NR = (PW+1)'(N_REQ);

   logic [PW-1:0]  ptr_q, ptr_d;
   logic [AW-1:0]  wra_q, wra_d;
   logic [DW-1:0]  di_q, di_d;
   logic           wr_q, wr_d;
   logic [31:0]    busy_q, busy_d;

   logic           found;
   logic [PW-1:0]  win;
   logic [PW:0]    idx;
   logic           hs;
   logic [AW-1:0]  win_addr;
   logic [DW-1:0]  win_data;

   // Scan ptr, ptr+1, ... wrapping at N_REQ; the first valid requester wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = {1'b0, ptr_q} + (PW+1)'(k);
         if (idx >= NR) idx = idx - NR;
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            win   = idx[PW-1:0];
         end
      end
   end

   assign hs       = found & ~bus.hold & rst;
   assign win_addr = bus.req_addr[win*AW +: AW];
   assign win_data = bus.req_data[win*DW +: DW];

   always_comb begin
      bus.req_ready = '0;
      if (hs) bus.req_ready[win] = 1'b1;
   end

   always_comb begin
      ptr_d = ptr_q;
      wra_d = wra_q;
      di_d  = di_q;
      wr_d  = 1'b0;
      if (hs) begin
         ptr_d = (win == PW'(N_REQ-1)) ? '0 : win + 1'b1;
         wra_d = win_addr;
         di_d  = win_data;
         wr_d  = (win_addr != '0);
      end
   end

   // Clear first so a same-cycle issue to the written register keeps it busy.
   always_comb begin
      busy_d = busy_q;
      if (wr_q) busy_d[wra_q] = 1'b0;
      if (bus.issue_valid && bus.issue_addr != '0) busy_d[bus.issue_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q  <= '0;
         wra_q  <= '0;
         di_q   <= '0;
         wr_q   <= 1'b0;
         busy_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         wra_q  <= wra_d;
         di_q   <= di_d;
         wr_q   <= wr_d;
         busy_q <= busy_d;
      end
   end

   assign bus.dir_wra   = wra_q;
   assign bus.di        = di_q;
   assign bus.reg_wr    = wr_q;
   assign bus.busy      = busy_q;
   assign bus.rd_hazard = busy_q[bus.rd_addr_a] | busy_q[bus.rd_addr_b];
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench: stimulus pushes expected bank writes into a queue, a negedge
// monitor pops and compares every reg_wr pulse; inline checks cover the rest.
module tb_regfile_wr_arbiter;
   localparam int N_REQ = 3;
   localparam int DW    = 32;
   localparam int AW    = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   regfile_wr_arbiter_if #(.N_REQ(N_REQ), .DW(DW), .AW(AW)) bus ();

   regfile_wr_arbiter #(.N_REQ(N_REQ), .DW(DW), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  tests = 0;
   int  fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req_valid[i]          = v;
      bus.req_addr[i*AW +: AW]  = a;
      bus.req_data[i*DW +: DW]  = d;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every bank write must match the head of the expected queue.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && bus.reg_wr) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected none", bus.dir_wra, bus.di);
            end else begin
               wr_t w;
               w = exp_q.pop_front();
               chk("wr_addr", 64'(bus.dir_wra), 64'(w.addr));
               chk("wr_data", 64'(bus.di), 64'(w.data));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.req_valid   = '0;
      bus.req_addr    = '0;
      bus.req_data    = '0;
      bus.hold        = 1'b0;
      bus.issue_valid = 1'b0;
      bus.issue_addr  = '0;
      bus.rd_addr_a   = '0;
      bus.rd_addr_b   = '0;

      // Reset state; valid requests must not be granted while rst is low.
      #2;
      bus.req_valid = 3'b111;
      #1;
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_reg_wr", 64'(bus.reg_wr), 64'd0);
      chk("rst_dir_wra", 64'(bus.dir_wra), 64'd0);
      chk("rst_di", 64'(bus.di), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      bus.req_valid = '0;
      step();
      step();
      rst = 1'b1;
      step();

      // Single requester 1.
      set_req(1, 1'b1, 5'd7, 32'h0000DDDD);
      #1;
      chk("r1_ready", 64'(bus.req_ready), 64'b010);
      push(5'd7, 32'h0000DDDD);
      step();
      set_req(1, 1'b0, '0, '0);
      chk("r1_dir_wra", 64'(bus.dir_wra), 64'd7);
      chk("r1_di", 64'(bus.di), 64'h0000DDDD);
      chk("r1_reg_wr", 64'(bus.reg_wr), 64'd1);

      // ptr is 2: grant requester 2 once to bring ptr back to 0.
      set_req(2, 1'b1, 5'd9, 32'h00002222);
      #1;
      chk("r2_ready", 64'(bus.req_ready), 64'b100);
      push(5'd9, 32'h00002222);
      step();
      set_req(2, 1'b0, '0, '0);

      // All valid for three cycles: grants 0,1,2 back-to-back.
      set_req(0, 1'b1, 5'd10, 32'hA0A0A0A0);
      set_req(1, 1'b1, 5'd11, 32'hA1A1A1A1);
      set_req(2, 1'b1, 5'd12, 32'hA2A2A2A2);
      #1;
      chk("rr_ready0", 64'(bus.req_ready), 64'b001);
      push(5'd10, 32'hA0A0A0A0);
      step();
      #1;
      chk("rr_ready1", 64'(bus.req_ready), 64'b010);
      push(5'd11, 32'hA1A1A1A1);
      step();
      #1;
      chk("rr_ready2", 64'(bus.req_ready), 64'b100);
      push(5'd12, 32'hA2A2A2A2);
      step();
      chk("rr_reg_wr_last", 64'(bus.reg_wr), 64'd1);

      // Hold freezes grants and ptr.
      bus.hold = 1'b1;
      #1;
      chk("hold_ready", 64'(bus.req_ready), 64'd0);
      step();
      chk("hold_reg_wr", 64'(bus.reg_wr), 64'd0);
      bus.hold = 1'b0;
      #1;
      chk("hold_ptr", 64'(bus.req_ready), 64'b001);
      push(5'd10, 32'hA0A0A0A0);
      step();
      bus.req_valid = '0;

      // Address 0: handshake, data loads, no write strobe.
      set_req(1, 1'b1, 5'd0, 32'h00005555);
      #1;
      chk("a0_ready", 64'(bus.req_ready), 64'b010);
      step();
      set_req(1, 1'b0, '0, '0);
      chk("a0_reg_wr", 64'(bus.reg_wr), 64'd0);
      chk("a0_di", 64'(bus.di), 64'h00005555);

      // Scoreboard hazard on register 3; address 0 never becomes busy.
      bus.issue_valid = 1'b1;
      bus.issue_addr  = 5'd3;
      step();
      bus.issue_addr  = 5'd0;
      step();
      bus.issue_valid = 1'b0;
      chk("busy_a0", 64'(bus.busy[0]), 64'd0);
      bus.rd_addr_a = 5'd3;
      #1;
      chk("haz_a", 64'(bus.rd_hazard), 64'd1);
      bus.rd_addr_a = 5'd0;
      bus.rd_addr_b = 5'd3;
      #1;
      chk("haz_b", 64'(bus.rd_hazard), 64'd1);
      set_req(0, 1'b1, 5'd3, 32'h00000033);
      #1;
      chk("haz_wr_ready", 64'(bus.req_ready), 64'b001);
      push(5'd3, 32'h00000033);
      step();
      set_req(0, 1'b0, '0, '0);
      chk("haz_during_wr", 64'(bus.rd_hazard), 64'd1);
      step();
      chk("haz_cleared", 64'(bus.rd_hazard), 64'd0);
      chk("busy3_clear", 64'(bus.busy[3]), 64'd0);
      bus.rd_addr_b = 5'd0;

      // Issue to 5 in the same cycle as the write to 5: set wins.
      bus.issue_valid = 1'b1;
      bus.issue_addr  = 5'd5;
      set_req(1, 1'b1, 5'd5, 32'h00000055);
      #1;
      chk("sw_ready", 64'(bus.req_ready), 64'b010);
      push(5'd5, 32'h00000055);
      step();
      set_req(1, 1'b0, '0, '0);
      chk("sw_busy_set", 64'(bus.busy), 64'h20);
      step();
      bus.issue_valid = 1'b0;
      chk("sw_busy_kept", 64'(bus.busy), 64'h20);

      // Mid-write reset discards the write and clears the scoreboard.
      bus.issue_valid = 1'b1;
      bus.issue_addr  = 5'd8;
      set_req(2, 1'b1, 5'd8, 32'h00000088);
      #1;
      chk("mr_ready", 64'(bus.req_ready), 64'b100);
      step();
      bus.issue_valid = 1'b0;
      set_req(2, 1'b0, '0, '0);
      chk("mr_reg_wr_pre", 64'(bus.reg_wr), 64'd1);
      rst = 1'b0;
      #1;
      chk("mr_reg_wr", 64'(bus.reg_wr), 64'd0);
      chk("mr_busy", 64'(bus.busy), 64'd0);
      chk("mr_dir_wra", 64'(bus.dir_wra), 64'd0);
      step();
      rst = 1'b1;
      step();
      chk("mr_no_wr", 64'(bus.reg_wr), 64'd0);
      step();

      // First grant after reset starts from ptr 0.
      set_req(0, 1'b1, 5'd4, 32'h00000044);
      set_req(1, 1'b1, 5'd6, 32'h00000066);
      #1;
      chk("post_rst_ready", 64'(bus.req_ready), 64'b001);
      push(5'd4, 32'h00000044);
      step();
      bus.req_valid = '0;
      step();
      step();
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
